// File: rtl/encod83_beh_if.sv
`default_nettype none
// ============================================================================
// encod83_beh_if : request/result bundle for the 8-to-3 priority encoder
// Rev 1.0
// ============================================================================
interface encod83_beh_if;
    logic       en;
    logic [7:0] in;
    logic [2:0] out;
    logic       valid;
    logic       multi;

    modport master (
        output en,
        output in,
        input  out,
        input  valid,
        input  multi
    );

    modport slave (
        input  en,
        input  in,
        output out,
        output valid,
        output multi
    );
endinterface
`default_nettype wire

// File: rtl/encod83_beh.sv
`default_nettype none
// ============================================================================
// encod83_beh : registered 8-to-3 priority encoder with enable, valid and
//               multi-hot flags; one-cycle latency, one encode per clock
// Rev 1.0
// ============================================================================
module encod83_beh (
    input  wire logic    clk,
    input  wire logic    rst_n,
    encod83_beh_if.slave bus
);

    localparam logic [3:0] c_MULTI_MIN = 4'd2;

    logic [2:0] w_idx;
    logic [3:0] w_cnt;

    logic [2:0] out_d,   out_q;
    logic       valid_d, valid_q;
    logic       multi_d, multi_q;

    // Ascending scan: the last set bit seen wins, so in[7] has top priority.
    always_comb begin
        w_idx = 3'd0;
        w_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.in[i]) begin
                w_idx = 3'(i);
                w_cnt = w_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        out_d   = 3'd0;
        valid_d = 1'b0;
        multi_d = 1'b0;
        if (bus.en) begin
            out_d   = w_idx;
            valid_d = |bus.in;
            multi_d = (w_cnt >= c_MULTI_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= 3'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.multi = multi_q;

endmodule
`default_nettype wire

// File: tb/tb_encod83_beh.sv
`default_nettype none
// ============================================================================
// tb_encod83_beh : self-checking bench for encod83_beh
// Rev 1.0
// ============================================================================
module tb_encod83_beh;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    encod83_beh_if bus ();

    encod83_beh dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {index, valid, multi} from the encoder's rules.
    function automatic logic [4:0] ref_model(input logic en, input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (!en) return 5'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
                break;
            end
        end
        return {idx, (v != 8'd0), ($countones(v) >= 2)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst_n  = 1'b0;
        bus.en = 1'b1;
        bus.in = 8'h80;
        for (int k = 0; k < 2; k++) begin
            step();
            got = {bus.out, bus.valid, bus.multi};
            checks++;
            if (got !== 5'd0) begin
                failures++;
                $display("FAIL reset_hold%0d got=%b want=%b", k, got, 5'd0);
            end
        end
        rst_n = 1'b1;
        step();
        got = {bus.out, bus.valid, bus.multi};
        checks++;
        if (got !== {3'd7, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_release got=%b want=%b", got, {3'd7, 1'b1, 1'b0});
        end
    endtask

    task automatic test_onehot();
        logic [4:0] got;
        logic [4:0] want;
        bus.en = 1'b1;
        for (int k = -1; k < 8; k++) begin
            bus.in = (k < 0) ? 8'h00 : (8'h01 << k);
            step();
            got  = {bus.out, bus.valid, bus.multi};
            want = (k < 0) ? 5'd0 : {3'(k), 1'b1, 1'b0};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL onehot_%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_priority();
        logic [7:0] pats  [3] = '{8'b0010_0101, 8'b1111_1111, 8'b0000_0011};
        logic [4:0] wants [3] = '{{3'd5, 2'b11}, {3'd7, 2'b11}, {3'd1, 2'b11}};
        logic [4:0] got;
        bus.en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in = pats[k];
            step();
            got = {bus.out, bus.valid, bus.multi};
            checks++;
            if (got !== wants[k]) begin
                failures++;
                $display("FAIL priority_%0d got=%b want=%b", k, got, wants[k]);
            end
        end
    endtask

    task automatic test_enable();
        logic [4:0] got;
        bus.en = 1'b0;
        bus.in = 8'b0100_0000;
        step();
        got = {bus.out, bus.valid, bus.multi};
        checks++;
        if (got !== 5'd0) begin
            failures++;
            $display("FAIL enable_off got=%b want=%b", got, 5'd0);
        end
        bus.en = 1'b1;
        step();
        got = {bus.out, bus.valid, bus.multi};
        checks++;
        if (got !== {3'd6, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL enable_on got=%b want=%b", got, {3'd6, 1'b1, 1'b0});
        end
    endtask

    task automatic test_sync_reset();
        logic [4:0] got;
        bus.en = 1'b1;
        bus.in = 8'b0001_0000;
        step();
        // Glitch rst_n low strictly between edges.
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
        got = {bus.out, bus.valid, bus.multi};
        checks++;
        if (got !== {3'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rst_glitch_between got=%b want=%b", got, {3'd4, 1'b1, 1'b0});
        end
        step();
        got = {bus.out, bus.valid, bus.multi};
        checks++;
        if (got !== {3'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rst_glitch_after got=%b want=%b", got, {3'd4, 1'b1, 1'b0});
        end
        rst_n = 1'b0;
        step();
        got = {bus.out, bus.valid, bus.multi};
        checks++;
        if (got !== 5'd0) begin
            failures++;
            $display("FAIL rst_edge got=%b want=%b", got, 5'd0);
        end
        rst_n = 1'b1;
        step();
        got = {bus.out, bus.valid, bus.multi};
        checks++;
        if (got !== {3'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rst_recover got=%b want=%b", got, {3'd4, 1'b1, 1'b0});
        end
    endtask

    task automatic test_random();
        logic [4:0] got;
        logic [4:0] want;
        int         errs;
        errs = 0;
        for (int n = 0; n < 1200; n++) begin
            bus.en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       bus.in = 8'h01 << $urandom_range(0, 7);
                1:       bus.in = 8'h00;
                default: bus.in = 8'($urandom);
            endcase
            want = ref_model(bus.en, bus.in);
            step();
            got = {bus.out, bus.valid, bus.multi};
            checks++;
            if (got !== want) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d en=%b in=%b got=%b want=%b",
                             n, bus.en, bus.in, got, want);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.in   = 8'h00;
        #2;
        test_reset();
        test_onehot();
        test_priority();
        test_enable();
        test_sync_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
